multicycle_control_unit: RTL and testbench

- Multi-cycle RV32I control FSM; successor to the single-cycle combinational decoder.
- Sequences fetch, decode, execute, memory and writeback over several cycles.
- Uses req/ack handshakes with instruction and data memory.
- Adds branch/JAL/JALR control, PC write control, illegal-opcode trapping and a parametrised memory-wait timeout.
- Sits between the instruction register (IR) and the shared datapath (ALU, register file, immediate generator, data memory).

---
 rtl/multicycle_control_unit.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM; INSTRET_COUNTER_EN adds the instret retired-instruction counter port.
// Latency with zero-wait acks: branch 3, ALU/LUI/AUIPC/JAL/JALR/store 4, load 5 cycles.
// Backpressure: im_req/dm_req held until ack; MEM_TIMEOUT unacked cycles (0 = never) trap with bus_error.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             branch_taken,
    input  logic             im_ack,
    input  logic             dm_ack,
    output logic             im_req,
    output logic             ir_write,
    output logic             dm_req,
    output logic             dm_write,
    output logic [2:0]       dm_ctrl,
    output logic             ru_write,
    output logic [1:0]       ru_data_src,
    output logic [3:0]       alu_op,
    output logic [1:0]       alu_a_src,
    output logic             alu_b_src,
    output logic [2:0]       imm_src,
    output logic [4:0]       br_op,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             illegal_instr,
    output logic             bus_error
`ifdef INSTRET_COUNTER_EN
    ,
    output logic [CNT_W-1:0] instret
`endif
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam int              WCNT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic            TIMEOUT_EN = (MEM_TIMEOUT != 0);

    logic [2:0]        state, state_nx;
    logic [WCNT_W-1:0] wait_cnt, wait_nx;
    logic              illegal_q, bus_err_q;
    logic              legal, is_store, waiting, ack_now, timeout;
    logic [2:0]        imm_sel;
    logic              unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};
    assign is_store      = (opcode == OP_STORE);
    assign waiting       = (state == S_FETCH) || (state == S_MEM);
    assign ack_now       = (state == S_FETCH) ? im_ack : dm_ack;
    // An ack in the limit cycle wins over the timeout.
    assign timeout       = TIMEOUT_EN && waiting && !ack_now && (wait_cnt == WAIT_LAST);

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_AUIPC,
            OP_LUI, OP_BR, OP_JAL, OP_JALR: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        case (opcode)
            OP_STORE:         imm_sel = 3'b001;
            OP_BR:            imm_sel = 3'b010;
            OP_JAL:           imm_sel = 3'b011;
            OP_LUI, OP_AUIPC: imm_sel = 3'b100;
            default:          imm_sel = 3'b000;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  if (im_ack) state_nx = S_DECODE;
                      else if (timeout) state_nx = S_TRAP;
            S_DECODE: state_nx = legal ? S_EXEC : S_TRAP;
            S_EXEC:   if (opcode == OP_BR) state_nx = S_FETCH;
                      else if (opcode == OP_LOAD || is_store) state_nx = S_MEM;
                      else state_nx = S_WB;
            S_MEM:    if (dm_ack) state_nx = is_store ? S_FETCH : S_WB;
                      else if (timeout) state_nx = S_TRAP;
            S_WB:     state_nx = S_FETCH;
            default:  state_nx = S_TRAP;
        endcase
        wait_nx = (waiting && !ack_now && state_nx == state) ? wait_cnt + WCNT_W'(1) : '0;
    end

    always_comb begin
        im_req      = 1'b0;
        ir_write    = 1'b0;
        dm_req      = 1'b0;
        dm_write    = 1'b0;
        dm_ctrl     = 3'b000;
        ru_write    = 1'b0;
        ru_data_src = 2'b00;
        alu_op      = 4'b0000;
        alu_a_src   = 2'b00;
        alu_b_src   = 1'b0;
        imm_src     = 3'b000;
        br_op       = 5'b00000;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    im_req   = 1'b1;
                    ir_write = im_ack;
                end
                S_DECODE: imm_src = imm_sel;
                S_EXEC: begin
                    imm_src = imm_sel;
                    case (opcode)
                        OP_R:   alu_op = {funct7[5], funct3};
                        OP_IMM: begin
                            // Only shifts use funct7[5] (SRLI/SRAI); other immediates overlap it.
                            alu_op    = (funct3 == 3'b001 || funct3 == 3'b101) ?
                                        {funct7[5], funct3} : {1'b0, funct3};
                            alu_b_src = 1'b1;
                        end
                        OP_LOAD, OP_STORE, OP_JALR: alu_b_src = 1'b1;
                        OP_AUIPC: begin
                            alu_a_src = 2'b01;
                            alu_b_src = 1'b1;
                        end
                        OP_BR: begin
                            br_op    = {2'b01, funct3};
                            pc_write = 1'b1;
                            pc_src   = branch_taken ? 2'b01 : 2'b00;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    dm_req   = 1'b1;
                    dm_ctrl  = funct3;
                    dm_write = is_store;
                    pc_write = dm_ack && is_store;
                end
                S_WB: begin
                    ru_write = 1'b1;
                    pc_write = 1'b1;
                    case (opcode)
                        OP_LOAD: ru_data_src = 2'b01;
                        OP_LUI:  ru_data_src = 2'b11;
                        OP_JAL: begin
                            ru_data_src = 2'b10;
                            pc_src      = 2'b01;
                            br_op       = 5'b10000;
                        end
                        OP_JALR: begin
                            ru_data_src = 2'b10;
                            pc_src      = 2'b10;
                            br_op       = 5'b10000;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign illegal_instr = illegal_q & ~rst;
    assign bus_error     = bus_err_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            if (state == S_DECODE && !legal) illegal_q <= 1'b1;
            if (timeout) bus_err_q <= 1'b1;
        end
    end

`ifdef INSTRET_COUNTER_EN
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) instret_q <= '0;
        else if (pc_write && state != S_TRAP) instret_q <= instret_q + CNT_W'(1);
    end

    assign instret = rst ? '0 : instret_q;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: per-cycle expected control words built from instruction class.
module tb_multicycle_control_unit;
    localparam int TO = 8;

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_L     = 7'h03;
    localparam logic [6:0] OP_S     = 7'h23;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_B     = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;

    typedef struct packed {
        logic       im_req, ir_write, dm_req, dm_write;
        logic [2:0] dm_ctrl;
        logic       ru_write;
        logic [1:0] ru_data_src;
        logic [3:0] alu_op;
        logic [1:0] alu_a_src;
        logic       alu_b_src;
        logic [2:0] imm_src;
        logic [4:0] br_op;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       illegal_instr, bus_error;
    } ctl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic branch_taken = 1'b0, im_ack = 1'b0, dm_ack = 1'b0;
    logic im_req, ir_write, dm_req, dm_write, ru_write, alu_b_src, pc_write, illegal_instr, bus_error;
    logic [2:0] dm_ctrl, imm_src;
    logic [1:0] ru_data_src, alu_a_src, pc_src;
    logic [3:0] alu_op;
    logic [4:0] br_op;
`ifdef INSTRET_COUNTER_EN
    logic [31:0] instret;
    logic [31:0] model_instret = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    ctl_t obs;

    always #5 clk = ~clk;

    multicycle_control_unit #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .branch_taken(branch_taken), .im_ack(im_ack), .dm_ack(dm_ack),
        .im_req(im_req), .ir_write(ir_write), .dm_req(dm_req), .dm_write(dm_write),
        .dm_ctrl(dm_ctrl), .ru_write(ru_write), .ru_data_src(ru_data_src),
        .alu_op(alu_op), .alu_a_src(alu_a_src), .alu_b_src(alu_b_src),
        .imm_src(imm_src), .br_op(br_op), .pc_write(pc_write), .pc_src(pc_src),
        .illegal_instr(illegal_instr), .bus_error(bus_error)
`ifdef INSTRET_COUNTER_EN
        , .instret(instret)
`endif
    );

    assign obs = {im_req, ir_write, dm_req, dm_write, dm_ctrl, ru_write, ru_data_src, alu_op,
                  alu_a_src, alu_b_src, imm_src, br_op, pc_write, pc_src, illegal_instr, bus_error};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1: drive inputs, compare at the falling edge, advance one cycle.
    task automatic cyc(input logic ia, input logic da, input logic bt, input ctl_t exp, input string tag);
        im_ack = ia;
        dm_ack = da;
        branch_taken = bt;
        #4;
        check(tag, 32'(obs), 32'(exp));
`ifdef INSTRET_COUNTER_EN
        check({tag, "_instret"}, instret, model_instret);
        if (exp.pc_write) model_instret++;
`endif
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            OP_S:             return 3'b001;
            OP_B:             return 3'b010;
            OP_JAL:           return 3'b011;
            OP_LUI, OP_AUIPC: return 3'b100;
            default:          return 3'b000;
        endcase
    endfunction

    function automatic ctl_t exec_exp(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic bt);
        ctl_t e = '0;
        e.imm_src = imm_of(op);
        case (op)
            OP_R: e.alu_op = {f7[5], f3};
            OP_I: begin
                e.alu_op    = (f3 == 3'd1 || f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3};
                e.alu_b_src = 1'b1;
            end
            OP_L, OP_S, OP_JALR: e.alu_b_src = 1'b1;
            OP_AUIPC: begin
                e.alu_a_src = 2'b01;
                e.alu_b_src = 1'b1;
            end
            OP_B: begin
                e.br_op    = {2'b01, f3};
                e.pc_write = 1'b1;
                e.pc_src   = bt ? 2'b01 : 2'b00;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic ctl_t wb_exp(input logic [6:0] op);
        ctl_t e = '0;
        e.ru_write = 1'b1;
        e.pc_write = 1'b1;
        case (op)
            OP_L:   e.ru_data_src = 2'b01;
            OP_LUI: e.ru_data_src = 2'b11;
            OP_JAL: begin e.ru_data_src = 2'b10; e.pc_src = 2'b01; e.br_op = 5'b10000; end
            OP_JALR: begin e.ru_data_src = 2'b10; e.pc_src = 2'b10; e.br_op = 5'b10000; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) cyc(rb(), rb(), rb(), '0, "reset");
        rst = 1'b0;
`ifdef INSTRET_COUNTER_EN
        model_instret = '0;
`endif
    endtask

    task automatic do_fetch(input int im_d);
        ctl_t e;
        for (int i = 0; i <= im_d; i++) begin
            opcode = 7'($urandom);
            funct3 = 3'($urandom);
            funct7 = 7'($urandom);
            e = '0;
            e.im_req = 1'b1;
            e.ir_write = (i == im_d);
            cyc(i == im_d, rb(), rb(), e, "fetch");
        end
    endtask

    task automatic do_front(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input int im_d, input logic bt);
        ctl_t e;
        do_fetch(im_d);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        e = '0;
        e.imm_src = imm_of(op);
        cyc(rb(), rb(), rb(), e, "decode");
        cyc(rb(), rb(), bt, exec_exp(op, f3, f7, bt), "exec");
    endtask

    task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input int im_d, input int dm_d, input logic bt);
        ctl_t e;
        do_front(op, f3, f7, im_d, bt);
        if (op == OP_L || op == OP_S) begin
            for (int i = 0; i <= dm_d; i++) begin
                e = '0;
                e.dm_req = 1'b1;
                e.dm_ctrl = f3;
                e.dm_write = (op == OP_S);
                e.pc_write = (op == OP_S) && (i == dm_d);
                cyc(rb(), i == dm_d, rb(), e, "mem");
            end
        end
        if (op != OP_B && op != OP_S) cyc(rb(), rb(), rb(), wb_exp(op), "wb");
    endtask

    logic [6:0] ops [9] = '{OP_R, OP_I, OP_L, OP_S, OP_AUIPC, OP_LUI, OP_B, OP_JAL, OP_JALR};

    initial begin
        ctl_t e;
        @(posedge clk);
        #1;
        do_reset(3);

        do_instr(OP_I, 3'd0, 7'd0, 0, 0, 1'b0);          // ADDI x1,x0,5
        do_instr(OP_L, 3'b010, 7'd0, 0, 3, 1'b0);        // LW, dm_ack after 3 waits
        do_instr(OP_B, 3'b000, 7'd0, 0, 0, 1'b1);        // BEQ taken
        do_instr(OP_B, 3'b000, 7'd0, 0, 0, 1'b0);        // BEQ not taken
        do_instr(OP_JALR, 3'b000, 7'd0, 0, 0, 1'b0);
        do_instr(OP_S, 3'b010, 7'd0, 0, 0, 1'b0);
        do_instr(OP_R, 3'b101, 7'h20, 1, 0, 1'b0);       // SRA
        do_instr(OP_I, 3'b101, 7'h20, 0, 0, 1'b0);       // SRAI
        do_instr(OP_I, 3'b110, 7'h20, 0, 0, 1'b0);       // ORI, funct7 bit ignored
        do_instr(OP_L, 3'b100, 7'd0, TO - 1, TO - 1, 1'b0); // acks in the limit cycle succeed
        do_instr(OP_S, 3'b000, 7'd0, TO - 1, TO - 1, 1'b0);

        for (int n = 0; n < 150; n++) begin
            int k = $urandom_range(0, 8);
            int imd = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2);
            int dmd = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2);
            do_instr(ops[k], 3'($urandom), 7'($urandom), imd, dmd, rb());
        end

        // Reset in the middle of a data access drops the request at once.
        do_front(OP_S, 3'b001, 7'd0, 0, 1'b0);
        e = '0; e.dm_req = 1'b1; e.dm_ctrl = 3'b001; e.dm_write = 1'b1;
        cyc(rb(), 1'b0, rb(), e, "mem_pre_abort");
        do_reset(1);
        do_instr(OP_LUI, 3'd0, 7'd0, 0, 0, 1'b0);

        // Illegal opcode traps and only reset clears it.
        do_fetch(0);
        opcode = 7'h7F; funct3 = 3'd0; funct7 = 7'd0;
        cyc(rb(), rb(), rb(), '0, "decode_illegal");
        for (int i = 0; i < 20; i++) begin
            e = '0; e.illegal_instr = 1'b1;
            cyc(rb(), rb(), rb(), e, "trap_illegal");
        end
        do_reset(1);
        do_instr(OP_JAL, 3'd0, 7'd0, 0, 0, 1'b0);

        // Data memory never acks.
        do_instr(OP_R, 3'd0, 7'd0, 0, 0, 1'b0);
        do_front(OP_L, 3'b010, 7'd0, 0, 1'b0);
        for (int i = 0; i < TO; i++) begin
            e = '0; e.dm_req = 1'b1; e.dm_ctrl = 3'b010;
            cyc(rb(), 1'b0, rb(), e, "mem_hang");
        end
        for (int i = 0; i < 6; i++) begin
            e = '0; e.bus_error = 1'b1;
            cyc(rb(), rb(), rb(), e, "trap_dm_timeout");
        end
        do_reset(2);

        // Instruction memory never acks.
        for (int i = 0; i < TO; i++) begin
            e = '0; e.im_req = 1'b1;
            cyc(1'b0, rb(), rb(), e, "fetch_hang");
        end
        for (int i = 0; i < 4; i++) begin
            e = '0; e.bus_error = 1'b1;
            cyc(rb(), rb(), rb(), e, "trap_im_timeout");
        end
        do_reset(1);
        do_instr(OP_AUIPC, 3'd0, 7'd0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
